// File: rtl/axi_arb_pkg.sv
// Shared constants and FSM state encoding for the AXI write-channel arbiter.
package axi_arb_pkg;

  localparam int NUM_MASTERS = 4;
  localparam int GRANT_W     = NUM_MASTERS;
  localparam int GRANT_ID_W  = $clog2(NUM_MASTERS);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_RESP = 2'd3
  } arb_state_e;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_picker
  import axi_arb_pkg::*;
(
  input  logic [GRANT_W-1:0]    req,
  input  logic [GRANT_ID_W-1:0] ptr,
  output logic [GRANT_W-1:0]    onehot,
  output logic [GRANT_ID_W-1:0] index,
  output logic                  any
);

  logic [GRANT_ID_W-1:0] cand;

  // NUM_MASTERS is a power of two, so the natural overflow of cand is the wrap.
  always_comb begin
    onehot = '0;
    index  = '0;
    any    = 1'b0;
    cand   = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      cand = ptr + GRANT_ID_W'(k);
      if (!any && req[cand]) begin
        any           = 1'b1;
        index         = cand;
        onehot[cand]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axi_write_arbiter.sv
// Round-robin write arbiter for 4 AXI masters: holds one grant from AW through B,
// with an optional idle-cycle watchdog that forces release of a stalled owner.
module axi_write_arbiter
  import axi_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [GRANT_W-1:0]    m_awvalid,
  input  logic                  s_awready,
  input  logic                  s_wvalid,
  input  logic                  s_wready,
  input  logic                  s_wlast,
  input  logic                  s_bvalid,
  input  logic                  s_bready,
  output logic [GRANT_W-1:0]    grant,
  output logic [GRANT_ID_W-1:0] grant_id,
  output logic                  busy,
  output logic                  timeout,
  output logic [1:0]            state_dbg
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

  arb_state_e            state;
  logic [GRANT_ID_W-1:0] rr_ptr;
  logic                  wdone;
  logic [CNT_W-1:0]      cnt;

  logic [GRANT_W-1:0]    pick_onehot;
  logic [GRANT_ID_W-1:0] pick_index;
  logic                  pick_any;

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid is never qualified by ready, only sampled together with it.
  logic aw_hs, w_hs, w_last_hs, b_hs, to_hit, release_b, release_t;

  assign aw_hs     = m_awvalid[grant_id] && s_awready;
  assign w_hs      = s_wvalid && s_wready;
  assign w_last_hs = w_hs && s_wlast;
  assign b_hs      = s_bvalid && s_bready;
  assign to_hit    = (TIMEOUT_CYCLES != 0) && (cnt == CNT_LAST);
  assign release_b = (state == ST_RESP) && b_hs;
  assign release_t = to_hit && (((state == ST_DATA) && !w_hs) ||
                                ((state == ST_RESP) && !b_hs));
  assign state_dbg = state;

  rr_picker u_picker (
    .req    (m_awvalid),
    .ptr    (rr_ptr),
    .onehot (pick_onehot),
    .index  (pick_index),
    .any    (pick_any)
  );

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state    <= ST_IDLE;
      grant    <= '0;
      grant_id <= '0;
      busy     <= 1'b0;
      timeout  <= 1'b0;
      rr_ptr   <= '0;
      wdone    <= 1'b0;
      cnt      <= '0;
    end else begin
      timeout <= 1'b0;
      if (release_b || release_t) begin
        // cnt is about to reach TIMEOUT_CYCLES on a stall edge: release now.
        state   <= ST_IDLE;
        grant   <= '0;
        busy    <= 1'b0;
        rr_ptr  <= grant_id + GRANT_ID_W'(1);
        wdone   <= 1'b0;
        cnt     <= '0;
        timeout <= release_t;
      end else begin
        case (state)
          ST_IDLE: begin
            wdone <= 1'b0;
            cnt   <= '0;
            if (pick_any) begin
              grant    <= pick_onehot;
              grant_id <= pick_index;
              busy     <= 1'b1;
              state    <= ST_ADDR;
            end else begin
              grant <= '0;
            end
          end
          ST_ADDR: begin
            if (w_last_hs) wdone <= 1'b1;
            if (aw_hs) begin
              state <= (wdone || w_last_hs) ? ST_RESP : ST_DATA;
              cnt   <= '0;
            end
          end
          ST_DATA: begin
            if (w_last_hs) begin
              state <= ST_RESP;
              cnt   <= '0;
            end else if (w_hs) begin
              cnt <= '0;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          ST_RESP: cnt <= cnt + CNT_W'(1);
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_axi_write_arbiter.sv
// Directed and randomized checks of axi_write_arbiter against a round-robin model.
module tb_axi_write_arbiter;
  import axi_arb_pkg::*;

  localparam int TO = 8;

  logic       aclk;
  logic       aresetn;
  logic [3:0] m_awvalid;
  logic       s_awready, s_wvalid, s_wready, s_wlast, s_bvalid, s_bready;
  logic [3:0] grant;
  logic [1:0] grant_id;
  logic       busy, timeout;
  logic [1:0] state_dbg;

  int total = 0;
  int bad   = 0;
  int ptr_m = 0;
  logic [1:0] exp_q[$];

  axi_write_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .m_awvalid (m_awvalid),
    .s_awready (s_awready),
    .s_wvalid  (s_wvalid),
    .s_wready  (s_wready),
    .s_wlast   (s_wlast),
    .s_bvalid  (s_bvalid),
    .s_bready  (s_bready),
    .grant     (grant),
    .grant_id  (grant_id),
    .busy      (busy),
    .timeout   (timeout),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // reference model: first requester at or after ptr, wrapping 3 -> 0
  function automatic int model_pick(input logic [3:0] req, input int ptr);
    for (int k = 0; k < 4; k++)
      if (req[(ptr + k) % 4]) return (ptr + k) % 4;
    return 0;
  endfunction

  task automatic check_held(input string tag, input int id);
    check({tag, "_grant"}, 32'(grant), 32'(1 << id));
    check({tag, "_id"}, 32'(grant_id), 32'(id));
    check({tag, "_busy"}, 32'(busy), 32'd1);
    check({tag, "_onehot"}, 32'($countones(grant) <= 1), 32'd1);
  endtask

  task automatic clear_inputs();
    m_awvalid = '0; s_awready = 0; s_wvalid = 0; s_wready = 0;
    s_wlast = 0; s_bvalid = 0; s_bready = 0;
  endtask

  // driver: one full transaction with random stalls (all shorter than TO)
  task automatic run_txn(input logic [3:0] req, input string tag);
    int id;
    int nb;
    m_awvalid = req;
    exp_q.push_back(2'(model_pick(req, ptr_m)));
    tick();
    id = int'(exp_q.pop_front());
    check_held({tag, "_grant"}, id);
    for (int s = 0; s < int'($urandom_range(0, 2)); s++) begin
      s_awready = 0;
      tick();
      check_held({tag, "_addr_stall"}, id);
    end
    s_awready = 1;
    tick();
    s_awready = 0;
    check({tag, "_data_state"}, 32'(state_dbg), 32'(ST_DATA));
    nb = $urandom_range(0, 3);
    for (int b = 0; b <= nb; b++) begin
      for (int s = 0; s < int'($urandom_range(0, 2)); s++) begin
        s_wvalid = 0;
        m_awvalid = 4'($urandom_range(0, 15));
        tick();
        check_held({tag, "_w_stall"}, id);
      end
      s_wvalid = 1; s_wready = 1; s_wlast = (b == nb);
      tick();
      s_wvalid = 0; s_wready = 0; s_wlast = 0;
    end
    check({tag, "_resp_state"}, 32'(state_dbg), 32'(ST_RESP));
    for (int s = 0; s < int'($urandom_range(0, 3)); s++) begin
      tick();
      check_held({tag, "_b_stall"}, id);
    end
    s_bvalid = 1; s_bready = 1;
    tick();
    s_bvalid = 0; s_bready = 0;
    check({tag, "_rel_grant"}, 32'(grant), 32'd0);
    check({tag, "_rel_busy"}, 32'(busy), 32'd0);
    check({tag, "_rel_to"}, 32'(timeout), 32'd0);
    ptr_m = (id + 1) % 4;
    m_awvalid = req;
  endtask

  initial begin
    clear_inputs();
    aresetn = 0;
    tick();
    tick();
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_id", 32'(grant_id), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_timeout", 32'(timeout), 32'd0);
    aresetn = 1;
    ptr_m = 0;
    tick();

    // single requester 2 after reset
    run_txn(4'b0100, "single2");
    m_awvalid = '0;
    tick();

    // all request continuously: order 0,1,2,3,0 after reset
    aresetn = 0;
    tick();
    aresetn = 1;
    ptr_m = 0;
    for (int t = 0; t < 5; t++) begin
      exp_q.push_back(2'(t % 4));
      check("rr_model_order", 32'(model_pick(4'b1111, ptr_m)), 32'(exp_q.pop_front()));
      run_txn(4'b1111, "rr_all");
    end
    m_awvalid = '0;
    tick();

    // random request patterns
    for (int t = 0; t < 10; t++) begin
      run_txn(4'($urandom_range(1, 15)), "rand");
      m_awvalid = '0;
      if ($urandom_range(0, 1) == 1) tick();
    end

    // W-last before AW: skip DATA
    m_awvalid = 4'b0001;
    tick();
    check_held("wfirst_grant", 0);
    s_wvalid = 1; s_wready = 1; s_wlast = 1;
    tick();
    s_wvalid = 0; s_wready = 0; s_wlast = 0;
    check("wfirst_still_addr", 32'(state_dbg), 32'(ST_ADDR));
    tick();
    check("wfirst_addr2", 32'(state_dbg), 32'(ST_ADDR));
    s_awready = 1;
    tick();
    s_awready = 0; m_awvalid = '0;
    check("wfirst_resp", 32'(state_dbg), 32'(ST_RESP));
    check_held("wfirst_held", 0);
    s_bvalid = 1; s_bready = 1;
    tick();
    s_bvalid = 0; s_bready = 0;
    check("wfirst_idle", 32'(state_dbg), 32'(ST_IDLE));
    check("wfirst_busy", 32'(busy), 32'd0);
    ptr_m = 1;

    // AW and W-last in the same ADDR cycle
    m_awvalid = 4'b0010;
    tick();
    check_held("same_grant", 1);
    s_awready = 1; s_wvalid = 1; s_wready = 1; s_wlast = 1;
    tick();
    s_awready = 0; s_wvalid = 0; s_wready = 0; s_wlast = 0; m_awvalid = '0;
    check("same_resp", 32'(state_dbg), 32'(ST_RESP));
    s_bvalid = 1; s_bready = 1;
    tick();
    s_bvalid = 0; s_bready = 0;
    check("same_idle", 32'(state_dbg), 32'(ST_IDLE));
    ptr_m = 2;

    // stall B: timeout after TO idle cycles
    m_awvalid = 4'b0100;
    tick();
    check_held("to_grant", 2);
    s_awready = 1;
    tick();
    s_awready = 0; m_awvalid = '0;
    s_wvalid = 1; s_wready = 1; s_wlast = 1;
    tick();
    s_wvalid = 0; s_wready = 0; s_wlast = 0;
    check("to_resp", 32'(state_dbg), 32'(ST_RESP));
    for (int i = 1; i < TO; i++) begin
      tick();
      check("to_wait_pulse", 32'(timeout), 32'd0);
      check_held("to_wait", 2);
    end
    tick();
    check("to_pulse", 32'(timeout), 32'd1);
    check("to_grant0", 32'(grant), 32'd0);
    check("to_busy0", 32'(busy), 32'd0);
    check("to_idle", 32'(state_dbg), 32'(ST_IDLE));
    ptr_m = 3;
    tick();
    check("to_pulse_end", 32'(timeout), 32'd0);
    run_txn(4'b1111, "after_to");
    m_awvalid = '0;
    tick();

    // reset during DATA while master 1 is granted
    aresetn = 0;
    tick();
    aresetn = 1;
    ptr_m = 0;
    m_awvalid = 4'b0010;
    tick();
    check_held("mid_grant", 1);
    s_awready = 1;
    tick();
    s_awready = 0; m_awvalid = '0;
    check("mid_data", 32'(state_dbg), 32'(ST_DATA));
    #2 aresetn = 0;
    #1;
    check("mid_rst_grant", 32'(grant), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_id", 32'(grant_id), 32'd0);
    check("mid_rst_to", 32'(timeout), 32'd0);
    check("mid_rst_state", 32'(state_dbg), 32'(ST_IDLE));
    tick();
    aresetn = 1;
    tick();
    check("mid_after_to", 32'(timeout), 32'd0);
    m_awvalid = 4'b0011;
    tick();
    check("mid_next_grant", 32'(grant), 32'(1 << model_pick(4'b0011, ptr_m)));
    check("mid_next_id", 32'(grant_id), 32'd0);
    m_awvalid = '0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
